// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AMBA AHB encodings and the FSM state type used by ahb_picomem_slave
// and its helpers.
//   HTRANS_* : transfer type codes (IDLE, BUSY, NONSEQ, SEQ)
//   HRESP_*  : response codes (only OKAY and ERROR are ever driven)
//   HSIZE_*  : transfer size codes supported by the native interface
//   state_e  : bus-side FSM states of the slave
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_picomem_slave_if.sv
// ahb_picomem_slave_if
// GRLIB-style AHB slave-side bus bundle.
//   slave  modport : view of the responding slave (drives HRDATA/HREADYOUT/HRESP)
//   master modport : view of the bus/master side (drives address/control/data)
interface ahb_picomem_slave_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

endinterface

// File: rtl/ahb_picomem_strb.sv
// ahb_picomem_strb
// Combinational size/offset decoder for native-interface slaves. Produces the
// byte-enable mask in GRLIB big-endian lane order (byte 0 on bits 31:24) and a
// legality flag for the transfer.
//   hsize   in  3 : AHB HSIZE
//   addr_lo in  2 : HADDR[1:0]
//   hwrite  in  1 : 1 = write (strobes are forced to zero for reads)
//   wstrb   out 4 : native byte enables
//   legal   out 1 : transfer size/alignment is supported
module ahb_picomem_strb
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] wstrb,
  output logic       legal
);

  logic [3:0] lanes;

  always_comb begin
    lanes = 4'b0000;
    legal = 1'b1;
    case (hsize)
      HSIZE_BYTE: lanes = 4'b1000 >> addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) legal = 1'b0;
        else            lanes = addr_lo[1] ? 4'b0011 : 4'b1100;
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) legal = 1'b0;
        else                  lanes = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
    wstrb = hwrite ? lanes : 4'b0000;
  end

endmodule

// File: rtl/ahb_picomem_slave.sv
// ahb_picomem_slave
// AHB slave that turns each accepted AHB transfer into one PicoRV32-style
// native memory request. Wait states follow mem_ready; a hung target is
// converted into a two-cycle AHB ERROR after TIMEOUT_CYCLES (0 = no timeout).
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   ahb           : AHB slave bundle (address/control/data in, HRDATA/HREADYOUT/HRESP out)
//   mem_valid     : native request, high for the whole ACCESS state
//   mem_instr     : request is an opcode fetch (HPROT[0]=0)
//   mem_addr      : word-aligned request address
//   mem_wdata     : write data, passed straight from HWDATA during ACCESS
//   mem_wstrb     : byte enables, 0000 for reads
//   mem_ready     : target completion
//   mem_rdata     : read data, valid with mem_ready
module ahb_picomem_slave
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb_picomem_slave_if.slave  ahb,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_e           state, state_d;
  logic             accept_p0;
  logic             legal_p0;
  logic [3:0]       wstrb_p0;
  logic             go_access;
  logic             timeout_hit;

  logic [31:0]      addr_p1;
  logic [3:0]       wstrb_p1;
  logic             write_p1;
  logic             instr_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [31:0]      hrdata_p1;

  // Address phase: decode lanes/legality of the transfer on the bus.
  ahb_picomem_strb u_strb (
    .hsize   (ahb.HSIZE),
    .addr_lo (ahb.HADDR[1:0]),
    .hwrite  (ahb.HWRITE),
    .wstrb   (wstrb_p0),
    .legal   (legal_p0)
  );

  // ERR2 and RESP both end a data phase with HREADYOUT=1, so they accept a
  // new address phase exactly like IDLE does.
  assign accept_p0 = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] &
                     ((state == ST_IDLE) | (state == ST_RESP) | (state == ST_ERR2));
  assign go_access = accept_p0 & legal_p0;

  // mem_ready wins over a simultaneous timeout because it is tested first below.
  assign timeout_hit = TIMEOUT_EN && (cnt_p1 == CNT_LIMIT);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (accept_p0) state_d = legal_p0 ? ST_ACCESS : ST_ERR1;
        else           state_d = ST_IDLE;
      end
      ST_ACCESS: begin
        if (mem_ready)        state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Data phase: request attributes captured at accept, held through ACCESS.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_p1  <= '0;
      wstrb_p1 <= '0;
      write_p1 <= 1'b0;
      instr_p1 <= 1'b0;
    end else if (go_access) begin
      addr_p1  <= {ahb.HADDR[31:2], 2'b00};
      wstrb_p1 <= wstrb_p0;
      write_p1 <= ahb.HWRITE;
      instr_p1 <= ~ahb.HPROT[0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                               cnt_p1 <= '0;
    else if (go_access)                         cnt_p1 <= '0;
    else if ((state == ST_ACCESS) && !mem_ready) cnt_p1 <= cnt_p1 + 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      hrdata_p1 <= '0;
    else if ((state == ST_ACCESS) && mem_ready && !write_p1)
      hrdata_p1 <= mem_rdata;
  end

  assign mem_valid = (state == ST_ACCESS);
  assign mem_addr  = addr_p1;
  assign mem_wstrb = mem_valid ? wstrb_p1 : 4'b0000;
  assign mem_instr = mem_valid & instr_p1;
  // The master holds HWDATA while HREADYOUT is low, so no capture is needed.
  assign mem_wdata = (mem_valid && write_p1) ? ahb.HWDATA : 32'h0;

  assign ahb.HRDATA    = hrdata_p1;
  assign ahb.HREADYOUT = (state != ST_ACCESS) && (state != ST_ERR1);
  assign ahb.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR
                                                                     : HRESP_OKAY;

  // Bits that carry no meaning here: bursts are handled beat by beat, only
  // HPROT[0] and HTRANS[1] matter.
  logic unused_bits;
  assign unused_bits = ^{ahb.HBURST, ahb.HPROT[3:1], ahb.HTRANS[0]};

endmodule
